// File: rtl/lifo_pkg.sv
// Shared types for the ready/valid stack: the per-cycle operation decoded
// from the push and pop handshakes.
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } op_e;

  function automatic op_e decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   decode_op = OP_PUSH;
      2'b01:   decode_op = OP_POP;
      2'b11:   decode_op = OP_SWAP;
      default: decode_op = OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ram_1r1w_sync.sv
// One-write one-read RAM with a registered read port; a read and a write to
// the same address on the same edge return the old contents.
module ram_1r1w_sync #(
  parameter int width_p = 8,
  parameter int depth_p = 8,
  localparam int addr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 w_v_i,
  input  logic [addr_w_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]   w_data_i,
  input  logic                 r_v_i,
  input  logic [addr_w_lp-1:0] r_addr_i,
  output logic [width_p-1:0]   r_data_o
);

  logic [width_p-1:0] r_mem [depth_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) r_mem[w_addr_i] <= w_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)    r_data_o <= '0;
    else if (r_v_i) r_data_o <= r_mem[r_addr_i];
  end

endmodule

// File: rtl/lifo_1r1w.sv
// Ready/valid LIFO stack: the top entry lives in a register, lower entries in
// a synchronous RAM, so data_o is valid with zero latency after any push/pop.
module lifo_1r1w
  import lifo_pkg::*;
#(
  parameter int width_p      = 8,
  parameter int depth_log2_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);

  localparam int                cap_lp = 1 << depth_log2_p;
  localparam logic [depth_log2_p:0] cap_c = (depth_log2_p + 1)'(cap_lp);

  logic [depth_log2_p:0]   r_count;
  logic [width_p-1:0]      r_top;
  logic [width_p-1:0]      r_byp_data;
  logic                    r_byp_v;

  logic                    w_push;
  logic                    w_pop;
  op_e                     w_op;
  logic [depth_log2_p:0]   w_count_next;
  logic [depth_log2_p-1:0] w_rd_addr;
  logic [depth_log2_p-1:0] w_wr_addr;
  logic                    w_wr_en;
  logic [width_p-1:0]      w_rd_data;

  // Flags come from the count alone, so a full stack refuses a push even
  // when a pop happens on the same edge.
  assign ready_o = (r_count != cap_c);
  assign valid_o = (r_count != '0);
  assign data_o  = r_top;

  assign w_push = valid_i & ready_o;
  assign w_pop  = valid_o & ready_i;
  assign w_op   = decode_op(w_push, w_pop);

  always_comb begin
    w_count_next = r_count;
    case (w_op)
      OP_PUSH: w_count_next = r_count + 1'b1;
      OP_POP:  w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Read address targets entry count-2 of the next cycle; write spills the
  // old top into slot count-1 when something is already on the stack.
  assign w_rd_addr = w_count_next[depth_log2_p-1:0] - depth_log2_p'(2);
  assign w_wr_addr = r_count[depth_log2_p-1:0] - depth_log2_p'(1);
  assign w_wr_en   = (w_op == OP_PUSH) && (r_count != '0);

  ram_1r1w_sync #(
    .width_p (width_p),
    .depth_p (cap_lp)
  ) u_ram (
    .clk_i    (clk_i),
    .reset_i  (~reset_ni),
    .w_v_i    (w_wr_en),
    .w_addr_i (w_wr_addr),
    .w_data_i (r_top),
    .r_v_i    (1'b1),
    .r_addr_i (w_rd_addr),
    .r_data_o (w_rd_data)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_count    <= '0;
      r_top      <= '0;
      r_byp_data <= '0;
      r_byp_v    <= 1'b0;
    end else begin
      r_count <= w_count_next;
      // The RAM read launched this edge misses the spill written on the same
      // edge, so the spilled value is held here for an immediate pop.
      r_byp_v <= w_wr_en;
      if (w_wr_en) r_byp_data <= r_top;
      case (w_op)
        OP_PUSH, OP_SWAP: r_top <= data_i;
        OP_POP:           r_top <= r_byp_v ? r_byp_data : w_rd_data;
        default:          r_top <= r_top;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_1r1w.sv
// Self-checking bench for lifo_1r1w (capacity 4) against a queue-based stack.
module tb_lifo_1r1w;

  localparam int W   = 8;
  localparam int CAP = 4;

  logic         clk;
  logic         reset_ni;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic         ready_i;

  int checks;
  int failures;

  logic [W-1:0] exp_q[$];

  lifo_1r1w #(.width_p(W), .depth_log2_p(2)) dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .ready_i  (ready_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset_ni = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    data_i   = '0;
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;
    exp_q.delete();
  endtask

  // driver: called at a negedge, applies inputs for one edge, updates the
  // reference stack with the handshake outcome, returns at the next negedge
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    logic m_push, m_pop;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    m_push  = v && (exp_q.size() < CAP);
    m_pop   = r && (exp_q.size() > 0);
    @(posedge clk);
    if (m_push && m_pop)  exp_q[exp_q.size()-1] = d;
    else if (m_push)      exp_q.push_back(d);
    else if (m_pop)       void'(exp_q.pop_back());
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    data_i   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_held: valid=%b ready=%b data=%h want 0 1 00", valid_o, ready_o, data_o);
    end
    reset_ni = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: valid=%b ready=%b want 0 1", valid_o, ready_o);
    end
    drive(1'b1, 8'h5A, 1'b0);
    drive(1'b1, 8'h6B, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 8'h6B) begin
      failures++;
      $display("FAIL reset_pre_traffic: valid=%b data=%h want 1 6b", valid_o, data_o);
    end
    #2 reset_ni = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_async: valid=%b ready=%b data=%h want 0 1 00", valid_o, ready_o, data_o);
    end
    @(negedge clk);
    reset_ni = 1'b1;
    exp_q.delete();
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_empty_after: valid=%b want 0", valid_o);
    end
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    apply_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, vals[i], 1'b0);
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      failures++;
      $display("FAIL fill_full: ready=%b valid=%b want 0 1", ready_o, valid_o);
    end
    for (int i = 3; i >= 0; i--) begin
      checks++;
      if (data_o !== vals[i] || valid_o !== 1'b1) begin
        failures++;
        $display("FAIL drain_order[%0d]: data=%h valid=%b want %h 1", i, data_o, valid_o, vals[i]);
      end
      drive(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL drain_empty: valid=%b ready=%b want 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_bypass();
    apply_reset();
    drive(1'b1, 8'hA0, 1'b0);
    drive(1'b1, 8'hA1, 1'b0);
    checks++;
    if (data_o !== 8'hA1) begin
      failures++;
      $display("FAIL bypass_top: data=%h want a1", data_o);
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (data_o !== 8'hA0 || valid_o !== 1'b1) begin
      failures++;
      $display("FAIL bypass_pop: data=%h valid=%b want a0 1", data_o, valid_o);
    end
  endtask

  task automatic test_swap();
    apply_reset();
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h55, 1'b1);
    checks++;
    if (data_o !== 8'h55 || dut.r_count !== 3'd2) begin
      failures++;
      $display("FAIL swap: data=%h count=%0d want 55 2", data_o, dut.r_count);
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (data_o !== 8'h01 || valid_o !== 1'b1) begin
      failures++;
      $display("FAIL swap_pop: data=%h valid=%b want 01 1", data_o, valid_o);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0);
    drive(1'b1, 8'h99, 1'b1);
    checks++;
    if (ready_o !== 1'b1 || dut.r_count !== 3'd3 || data_o !== 8'hC2) begin
      failures++;
      $display("FAIL full_push_pop: ready=%b count=%0d data=%h want 1 3 c2",
               ready_o, dut.r_count, data_o);
    end
  endtask

  task automatic test_random();
    int bad;
    apply_reset();
    bad = 0;
    for (int n = 0; n < 10000; n++) begin
      checks++;
      if (valid_o !== (exp_q.size() != 0) || ready_o !== (exp_q.size() != CAP) ||
          (exp_q.size() != 0 && data_o !== exp_q[exp_q.size()-1]) ||
          dut.r_count !== 3'(exp_q.size())) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: valid=%b ready=%b data=%h count=%0d want size=%0d top=%h",
                   n, valid_o, ready_o, data_o, dut.r_count, exp_q.size(),
                   (exp_q.size() != 0) ? exp_q[exp_q.size()-1] : 8'h00);
      end
      drive(1'($urandom_range(1, 0)), 8'($urandom), 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill_drain();
    test_bypass();
    test_swap();
    test_full_push_pop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
